// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer between a valid/ready producer and consumer.
// Entry "main" always drives out_data. Entry "skid" catches the one beat that
// arrives while the consumer is stalled, so in_ready can be a pure register
// output with no combinational dependency on out_ready.
//
// Optional feature: define PIPE_SKID_STALL_CNT_EN to build a saturating 16-bit
// count of back-pressure cycles on stall_cnt. When the macro is left undefined,
// stall_cnt is tied to zero and no counter flops exist.
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             in_ready_reg, out_valid_reg;
    logic [1:0]       count_reg, count_next;
    logic             in_xfer, out_xfer;

    // Handshakes use the registered flags, so nothing here depends on
    // out_ready for the in_ready output.
    assign in_xfer  = in_valid && in_ready_reg;
    assign out_xfer = out_valid_reg && out_ready;

    // Next-state and data-path selection. Flush overrides every transition
    // and leaves both data registers untouched.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (in_xfer) begin
                    main_next  = in_data;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_next = in_data;
                end else if (in_xfer) begin
                    skid_next  = in_data;
                    state_next = FULL;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so in_data is never sampled.
                if (out_xfer) begin
                    main_next  = skid_reg;
                    state_next = BUSY;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
            main_next  = main_reg;
            skid_next  = skid_reg;
        end
    end

    // Occupancy encoding of the upcoming state.
    always_comb begin
        count_next = 2'd0;
        case (state_next)
            BUSY:    count_next = 2'd1;
            FULL:    count_next = 2'd2;
            default: count_next = 2'd0;
        endcase
    end

    // State, data and handshake flags all register together, so each output is
    // a flop decoded one cycle ahead from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            count_reg     <= 2'd0;
        end else begin
            state_reg     <= state_next;
            main_reg      <= main_next;
            skid_reg      <= skid_next;
            in_ready_reg  <= (state_next != FULL);
            out_valid_reg <= (state_next != EMPTY);
            count_reg     <= count_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_reg;
    assign count     = count_reg;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Count cycles where a beat is offered but refused; a flush cycle is not
    // a stall. Saturates rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= 16'h0000;
        end else if (out_valid_reg && !out_ready && !flush && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed testbench for pipe_skid_reg: a table of single-cycle vectors plus
// hand-written sequences for asynchronous reset and the stall counter.
module tb_pipe_skid_reg;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;
    logic [15:0]      stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, sample one time unit after the rising edge.
    task automatic cycle(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
        @(negedge clk);
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic e_ir, input logic e_ov,
                                 input logic [31:0] e_od, input logic [1:0] e_cnt);
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
        check({tag, ".out_data"},  out_data,           e_od);
        check({tag, ".count"},     {30'd0, count},     {30'd0, e_cnt});
    endtask

    logic [15:0] exp_stall;
    logic        prev_ov;

    initial begin
        //            flush iv  data   ordy  ir   ov   od     cnt
        // streaming 1..4 then drain
        vecs[0]  = '{1'b0, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1, 2'd1};
        vecs[1]  = '{1'b0, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h2, 2'd1};
        vecs[2]  = '{1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h3, 2'd1};
        vecs[3]  = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h4, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h4, 2'd0};
        // back-pressure: A held, B into skid, then FULL ignores C
        vecs[5]  = '{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA, 2'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2};
        vecs[8]  = '{1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2};
        vecs[9]  = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB, 2'd1};
        vecs[10] = '{1'b0, 1'b0, 32'hC, 1'b1, 1'b1, 1'b0, 32'hB, 2'd0};
        // BUSY hold and simultaneous in/out
        vecs[11] = '{1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h5, 2'd1};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h5, 2'd1};
        vecs[13] = '{1'b0, 1'b1, 32'h6, 1'b1, 1'b1, 1'b1, 32'h6, 2'd1};
        // flush from FULL, from EMPTY with a beat offered, and from BUSY
        vecs[14] = '{1'b0, 1'b1, 32'h7, 1'b0, 1'b0, 1'b1, 32'h6, 2'd2};
        vecs[15] = '{1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h6, 2'd0};
        vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h6, 2'd0};
        vecs[17] = '{1'b1, 1'b1, 32'h9, 1'b1, 1'b1, 1'b0, 32'h6, 2'd0};
        vecs[18] = '{1'b0, 1'b1, 32'hE, 1'b1, 1'b1, 1'b1, 32'hE, 2'd1};
        vecs[19] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hE, 2'd0};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b1, 1'b0, 32'h0, 2'd0);
        check("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        exp_stall = 16'd0;
        prev_ov   = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ordy);
`ifdef PIPE_SKID_STALL_CNT_EN
            if (prev_ov && !vecs[i].ordy && !vecs[i].flush)
                exp_stall = exp_stall + 16'd1;
`endif
            prev_ov = vecs[i].e_ov;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_cnt);
            check($sformatf("vec%0d.stall_cnt", i), {16'd0, stall_cnt}, {16'd0, exp_stall});
            $display("vec%0d: flush=%0b iv=%0b d=%0h ordy=%0b -> ir=%0b ov=%0b od=%0h cnt=%0d stall=%0d",
                     i, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ordy,
                     in_ready, out_valid, out_data, count, stall_cnt);
        end

        // Asynchronous reset mid-cycle while FULL.
        cycle(1'b0, 1'b1, 32'h21, 1'b0);
        cycle(1'b0, 1'b1, 32'h22, 1'b0);
        check_outputs("pre_areset", 1'b0, 1'b1, 32'h21, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("areset", 1'b1, 1'b0, 32'h0, 2'd0);
        check("areset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        $display("areset: ir=%0b ov=%0b od=%0h cnt=%0d", in_ready, out_valid, out_data, count);
        @(negedge clk);
        reset = 1'b0;
        // First edge after reset behaves as EMPTY; the held beats are gone.
        cycle(1'b0, 1'b1, 32'h33, 1'b1);
        check_outputs("post_reset", 1'b1, 1'b1, 32'h33, 2'd1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check_outputs("post_reset_drain", 1'b1, 1'b0, 32'h33, 2'd0);
        $display("post_reset: ir=%0b ov=%0b od=%0h cnt=%0d", in_ready, out_valid, out_data, count);

        // Long stall: one beat held with out_ready low.
        cycle(1'b0, 1'b1, 32'h44, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_SKID_STALL_CNT_EN
        check("stall_1", {16'd0, stall_cnt}, 32'd1);
        repeat (99) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_100", {16'd0, stall_cnt}, 32'd100);
        repeat (69900) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
`else
        repeat (99) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_off", {16'd0, stall_cnt}, 32'd0);
`endif
        check_outputs("stall_hold", 1'b1, 1'b1, 32'h44, 2'd1);
        $display("stall: od=%0h cnt=%0d stall_cnt=%0h", out_data, count, stall_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-005 SHALL have port in_valid  input  1  upstream beat offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  downstream beat offered.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the beat this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 SHALL have port count  output  2  occupancy: 0, 1 or 2 entries.
REQ-012 SHALL have port stall_cnt  output  16  downstream back-pressure cycle count (see Configuration).

Function
REQ-013 SHALL hold two WIDTH-bit registers, main and skid, and a 3-state FSM: EMPTY (0 entries), BUSY (main valid), FULL (main and skid valid).
REQ-014 SHALL complete an input transfer on a cycle with in_valid=1 and in_ready=1, and an output transfer on a cycle with out_valid=1 and out_ready=1.
REQ-015 SHALL drive in_ready=1 in EMPTY and BUSY, 0 in FULL; in_ready SHALL be a register output with no combinational path from out_ready.
REQ-016 SHALL drive out_valid=1 in BUSY and FULL, out_data=main, count=0/1/2 for EMPTY/BUSY/FULL.
REQ-017 EMPTY: input transfer -> main<=in_data, go BUSY; otherwise stay.
REQ-018 BUSY: input and output transfer -> main<=in_data, stay BUSY; input only -> skid<=in_data, go FULL; output only -> go EMPTY; neither -> stay.
REQ-019 FULL: output transfer -> main<=skid, go BUSY; otherwise stay; in_data is ignored.
REQ-020 Latency SHALL be one cycle: a beat accepted in EMPTY at edge N appears on out_data after edge N.
REQ-021 out_data SHALL remain unchanged while out_valid=1 and out_ready=0.
REQ-022 Beats SHALL leave in acceptance order; none dropped or duplicated except by flush or reset.
REQ-023 flush=1 SHALL force EMPTY at the next edge, override every other transition, and discard any beat offered that cycle even though in_ready=1.
REQ-024 main and skid contents SHALL NOT be cleared by flush; only state is.

Reset
REQ-025 reset=1 SHALL immediately, without clk, force EMPTY, main=0, skid=0, stall_cnt=0, giving out_valid=0, in_ready=1, count=0, out_data=0.
REQ-026 Reset asserted mid-transfer SHALL discard all held beats; the first post-reset edge behaves as EMPTY.

Configuration
REQ-027 Macro PIPE_SKID_STALL_CNT_EN SHALL control the stall counter.
REQ-028 With PIPE_SKID_STALL_CNT_EN defined, stall_cnt SHALL increment on every edge where out_valid=1 and out_ready=0 and flush=0, saturate at 16'hFFFF, and clear only on reset.
REQ-029 Without PIPE_SKID_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL be synthesized; all other behaviour identical.

Verification
REQ-030 Streaming: in_valid=1, out_ready=1 continuously, data 1,2,3,4 -> out_data 1,2,3,4 one cycle later each, count stays 1, in_ready stays 1.
REQ-031 Back-pressure: BUSY holding 0xA, out_ready=0, offer 0xB -> FULL, in_ready=0, out_data holds 0xA; out_ready=1 two cycles -> outputs 0xA then 0xB, then EMPTY.
REQ-032 FULL ignore: in FULL drive in_valid=1, in_data=0xC with out_ready=0 -> 0xC never appears on out_data.
REQ-033 Flush: FULL with in_valid=1, flush=1 for one cycle -> next cycle count=0, out_valid=0, in_ready=1; offered beat never emitted.
REQ-034 Async reset: assert reset between edges while FULL -> count=0, out_valid=0, out_data=0 before next posedge clk.
REQ-035 Stall counter (macro defined): hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; macro undefined -> stall_cnt=0.
